algo_2ror1w_b120_rd_buf: RTL and testbench
==========================================

# algo_2ror1w_b120_rd_buf

Read-return buffer directly downstream of the 2-read/1-write algorithmic memory top. It forwards host read requests to the memory and captures each port's returned read data, ECC flags and physical address into a per-port FIFO. Hosts then drain the FIFO under valid/ready backpressure. Per-port credit accounting gates read issue so a returning response always has a FIFO slot; the memory's fixed-latency, no-backpressure read path can never overflow.

## Interface
Parameters:
- WIDTH, 32, read data width per port
- BITADDR, 13, read address width
- BITPADR, 17, physical-address width per port
- DEPTH, 8, FIFO entries per port (≥ memory read latency + 1 for full throughput)
- BITDPTH, 3, log2(DEPTH)
- NUMRDPT, 2, read ports (fixed at 2)

Ports (clock and reset first; reset is asynchronous, active-low):
- clk  in  1  single clock
- rst  in  1  asynchronous active-low reset
- ready  in  1  memory ready
- hst_read  in  NUMRDPT  host read request, one per port
- hst_adr  in  NUMRDPT*BITADDR  host read address
- hst_rdy  out  NUMRDPT  port may issue a read this cycle
- read  out  NUMRDPT  read to memory, equal to hst_read & hst_rdy
- rd_adr  out  NUMRDPT*BITADDR  equal to hst_adr
- rd_vld  in  NUMRDPT  memory read return valid
- rd_dout  in  NUMRDPT*WIDTH  memory read data
- rd_serr  in  NUMRDPT  single-bit-error flag
- rd_derr  in  NUMRDPT  double-bit-error flag
- rd_padr  in  NUMRDPT*BITPADR  physical address
- out_vld  out  NUMRDPT  FIFO head valid
- out_rdy  in  NUMRDPT  host consumes head
- out_dout  out  NUMRDPT*WIDTH  head data
- out_serr  out  NUMRDPT  head single-bit-error flag
- out_derr  out  NUMRDPT  head double-bit-error flag
- out_padr  out  NUMRDPT*BITPADR  head physical address
- err_unexp  out  NUMRDPT  sticky: rd_vld arrived with no read in flight

## Operation
- Ports are fully independent; all state below is per port p.
- State:
  - cnt[BITDPTH:0]: FIFO occupancy.
  - infl[BITDPTH:0]: reads issued but not yet returned.
  - wptr, rptr[BITDPTH-1:0]: FIFO write and read pointers.
- avail = DEPTH − cnt − infl. Unsigned; the invariant cnt + infl ≤ DEPTH always holds.
- hst_rdy[p] = ready & (avail != 0). This is combinational from registers and ready only, never from hst_read.
- accept = hst_read[p] & hst_rdy[p]. read[p] = accept.
- push = rd_vld[p] & (infl != 0). Entry {rd_derr, rd_serr, rd_padr, rd_dout} is written at wptr and wptr increments mod DEPTH.
- rd_vld[p] with infl == 0:
  - Sets err_unexp[p].
  - Data is dropped; no counter changes.
  - err_unexp clears only on reset.
- pop = out_vld[p] & out_rdy[p]. rptr increments mod DEPTH.
- out_vld[p] = (cnt != 0). The out_* data fields show the entry at rptr and are undefined when out_vld = 0.
- Counter updates, all in the same cycle:
  - infl ← infl + accept − push
  - cnt ← cnt + push − pop
- Simultaneous push and pop at any occupancy (including cnt = DEPTH−1 or 1) is legal; cnt stays unchanged.
- With cnt = 0, a push becomes visible the next cycle. There is no fall-through.
- Pointer wrap from DEPTH−1 to 0 is silent.
- Overflow is impossible by construction. A push with cnt = DEPTH (which a correct memory cannot cause) is undefined behaviour and is flagged by assertion.

## Timing
- Reset (rst = 0, asynchronous assert, synchronous-to-clk deassert expected from upstream):
  - cnt, infl, wptr, rptr and err_unexp clear to 0.
  - out_vld = 0.
  - hst_rdy = 0 while ready = 0.
- Request path: hst_read → read is combinational, with zero added latency.
- Response to host:
  - rd_vld at cycle N → out_vld at N+1 if the FIFO was empty.
  - If the FIFO was non-empty, the entry is behind the older entries (FIFO order).
- Credit return:
  - pop at cycle N raises avail at N+1.
  - Return push does not free credit: it decrements infl but increments cnt.
- Reset mid-operation discards all buffered and in-flight state. Late returns for discarded reads set err_unexp.
- ready falling drops hst_rdy the same cycle. Already in-flight reads still return and are buffered normally.

## Test plan
- Reset, then ready = 1, no traffic → hst_rdy = 2'b11, out_vld = 0, err_unexp = 0.
- Port 0 reads address 0x0005, memory returns 0xDEADBEEF with serr = 1 and padr 0x1A2B two cycles later, out_rdy = 1 → out_vld[0] for exactly 1 cycle, one cycle after rd_vld, carrying 0xDEADBEEF, serr = 1, padr 0x1A2B.
- out_rdy[1] = 0, port 1 issues reads back-to-back → exactly 8 accepted, then hst_rdy[1] = 0. Raise out_rdy for 1 cycle → one pop, hst_rdy[1] = 1 the next cycle, one more accept.
- Both ports at full rate, out_rdy toggling 1010 for 100 reads each → no loss or reordering, the data sequence matches the addresses issued, port 0 and port 1 are independent.
- rd_vld[0] pulsed with infl = 0 → err_unexp[0] = 1 and stays set, cnt unchanged; err_unexp[1] stays 0.
- Async rst pulse with 3 entries buffered and 2 in flight → out_vld = 0 immediately. The 2 late returns set err_unexp; hst_rdy = 1 once ready is high.

Source files
------------

// File: rtl/algo_2ror1w_b120_rd_buf.sv
`default_nettype none
// ============================================================================
// Module      : algo_2ror1w_b120_rd_buf
// Description : Per-port read-return FIFO with credit-gated read issue for the
//               2R/1W algorithmic memory; responses always find a free slot.
// Revision    : 1.0 - initial release
// ============================================================================
module algo_2ror1w_b120_rd_buf #(
    parameter int WIDTH   = 32,
    parameter int BITADDR = 13,
    parameter int BITPADR = 17,
    parameter int DEPTH   = 8,
    parameter int BITDPTH = 3,
    parameter int NUMRDPT = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       ready,
    input  logic [NUMRDPT-1:0]         hst_read,
    input  logic [NUMRDPT*BITADDR-1:0] hst_adr,
    output logic [NUMRDPT-1:0]         hst_rdy,
    output logic [NUMRDPT-1:0]         read,
    output logic [NUMRDPT*BITADDR-1:0] rd_adr,
    input  logic [NUMRDPT-1:0]         rd_vld,
    input  logic [NUMRDPT*WIDTH-1:0]   rd_dout,
    input  logic [NUMRDPT-1:0]         rd_serr,
    input  logic [NUMRDPT-1:0]         rd_derr,
    input  logic [NUMRDPT*BITPADR-1:0] rd_padr,
    output logic [NUMRDPT-1:0]         out_vld,
    input  logic [NUMRDPT-1:0]         out_rdy,
    output logic [NUMRDPT*WIDTH-1:0]   out_dout,
    output logic [NUMRDPT-1:0]         out_serr,
    output logic [NUMRDPT-1:0]         out_derr,
    output logic [NUMRDPT*BITPADR-1:0] out_padr,
    output logic [NUMRDPT-1:0]         err_unexp
);

    localparam int               C_EW    = WIDTH + BITPADR + 2;
    localparam logic [BITDPTH:0] C_DEPTH = (BITDPTH+1)'(DEPTH);

    assign rd_adr = hst_adr;

    for (genvar p = 0; p < NUMRDPT; p++) begin : g_port
        logic [BITDPTH:0]   r_cnt;
        logic [BITDPTH:0]   r_infl;
        logic [BITDPTH-1:0] r_wptr;
        logic [BITDPTH-1:0] r_rptr;
        logic               r_err;
        logic [C_EW-1:0]    r_mem [DEPTH];
        logic [BITDPTH:0]   w_avail;
        logic               w_accept;
        logic               w_push;
        logic               w_pop;
        logic [C_EW-1:0]    w_head;

        // Credits cover both buffered entries and reads still in the memory pipe.
        assign w_avail    = C_DEPTH - r_cnt - r_infl;
        assign hst_rdy[p] = ready & (w_avail != '0);
        assign w_accept   = hst_read[p] & hst_rdy[p];
        assign read[p]    = w_accept;
        assign w_push     = rd_vld[p] & (r_infl != '0);
        assign out_vld[p] = (r_cnt != '0);
        assign w_pop      = out_vld[p] & out_rdy[p];

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                r_cnt  <= '0;
                r_infl <= '0;
                r_wptr <= '0;
                r_rptr <= '0;
                r_err  <= 1'b0;
            end else begin
                r_infl <= r_infl + {{BITDPTH{1'b0}}, w_accept} - {{BITDPTH{1'b0}}, w_push};
                r_cnt  <= r_cnt + {{BITDPTH{1'b0}}, w_push} - {{BITDPTH{1'b0}}, w_pop};
                // DEPTH is a power of two, so pointers wrap naturally.
                if (w_push) begin
                    r_wptr <= r_wptr + 1'b1;
                end
                if (w_pop) begin
                    r_rptr <= r_rptr + 1'b1;
                end
                if (rd_vld[p] && (r_infl == '0)) begin
                    r_err <= 1'b1;
                end
            end
        end

        always_ff @(posedge clk) begin
            if (w_push) begin
                r_mem[r_wptr] <= {rd_derr[p], rd_serr[p],
                                  rd_padr[p*BITPADR +: BITPADR], rd_dout[p*WIDTH +: WIDTH]};
            end
        end

        assign w_head                        = r_mem[r_rptr];
        assign out_dout[p*WIDTH +: WIDTH]    = w_head[WIDTH-1:0];
        assign out_padr[p*BITPADR +: BITPADR] = w_head[WIDTH +: BITPADR];
        assign out_serr[p]                   = w_head[WIDTH+BITPADR];
        assign out_derr[p]                   = w_head[WIDTH+BITPADR+1];
        assign err_unexp[p]                  = r_err;

        a_no_overflow : assert property (@(posedge clk) disable iff (!rst)
            !(w_push && (r_cnt == C_DEPTH)));
    end

endmodule
`default_nettype wire

// File: tb/tb_algo_2ror1w_b120_rd_buf.sv
`default_nettype none
// ============================================================================
// Module      : tb_algo_2ror1w_b120_rd_buf
// Description : Directed self-checking bench for the read-return buffer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_algo_2ror1w_b120_rd_buf;

    logic        clk = 1'b0;
    logic        rst;
    logic        ready;
    logic [1:0]  hst_read;
    logic [25:0] hst_adr;
    logic [1:0]  hst_rdy;
    logic [1:0]  read;
    logic [25:0] rd_adr;
    logic [1:0]  rd_vld;
    logic [63:0] rd_dout;
    logic [1:0]  rd_serr;
    logic [1:0]  rd_derr;
    logic [33:0] rd_padr;
    logic [1:0]  out_vld;
    logic [1:0]  out_rdy;
    logic [63:0] out_dout;
    logic [1:0]  out_serr;
    logic [1:0]  out_derr;
    logic [33:0] out_padr;
    logic [1:0]  err_unexp;

    // Manual response drive versus a 2-cycle latency memory model.
    logic        mem_en;
    logic [1:0]  man_vld, man_serr, man_derr;
    logic [63:0] man_dout;
    logic [33:0] man_padr;
    logic [1:0]  s1_vld = '0, s2_vld = '0;
    logic [25:0] s1_adr = '0, s2_adr = '0;
    logic [50:0] m0, m1;

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    algo_2ror1w_b120_rd_buf dut (
        .clk(clk), .rst(rst), .ready(ready),
        .hst_read(hst_read), .hst_adr(hst_adr), .hst_rdy(hst_rdy),
        .read(read), .rd_adr(rd_adr),
        .rd_vld(rd_vld), .rd_dout(rd_dout), .rd_serr(rd_serr),
        .rd_derr(rd_derr), .rd_padr(rd_padr),
        .out_vld(out_vld), .out_rdy(out_rdy), .out_dout(out_dout),
        .out_serr(out_serr), .out_derr(out_derr), .out_padr(out_padr),
        .err_unexp(err_unexp)
    );

    // Entry layout {derr, serr, padr, dout} derived purely from port and address.
    function automatic logic [50:0] f_ent(input int p, input logic [12:0] a);
        logic [31:0] d;
        logic [16:0] pa;
        d  = {4'hC, 3'b000, p[0], 11'h000, a};
        pa = {p[0], 3'b000, a};
        return {a[1] ^ p[0], a[0], pa, d};
    endfunction

    function automatic logic [50:0] head(input int p);
        return {out_derr[p], out_serr[p], out_padr[p*17 +: 17], out_dout[p*32 +: 32]};
    endfunction

    always @(posedge clk) begin
        s1_vld <= read & {2{mem_en}};
        s1_adr <= rd_adr;
        s2_vld <= s1_vld;
        s2_adr <= s1_adr;
    end

    assign m0      = f_ent(0, s2_adr[12:0]);
    assign m1      = f_ent(1, s2_adr[25:13]);
    assign rd_vld  = mem_en ? s2_vld : man_vld;
    assign rd_dout = mem_en ? {m1[31:0], m0[31:0]} : man_dout;
    assign rd_padr = mem_en ? {m1[48:32], m0[48:32]} : man_padr;
    assign rd_serr = mem_en ? {m1[49], m0[49]} : man_serr;
    assign rd_derr = mem_en ? {m1[50], m0[50]} : man_derr;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin : main
        logic [12:0] exp_adr;
        int          iss [2];
        int          pc  [2];
        logic [12:0] base [2];

        rst = 1'b0; ready = 1'b0; hst_read = '0; hst_adr = '0; out_rdy = '0;
        mem_en = 1'b0; man_vld = '0; man_serr = '0; man_derr = '0;
        man_dout = '0; man_padr = '0;
        base[0] = 13'h0200; base[1] = 13'h1400;

        // Reset state
        repeat (2) cyc();
        #2;
        chk("rst_out_vld", 64'(out_vld), 64'(2'b00));
        chk("rst_hst_rdy_notready", 64'(hst_rdy), 64'(2'b00));
        chk("rst_err", 64'(err_unexp), 64'(2'b00));
        cyc(); rst = 1'b1; ready = 1'b1; #2;
        chk("idle_hst_rdy", 64'(hst_rdy), 64'(2'b11));
        chk("idle_out_vld", 64'(out_vld), 64'(2'b00));
        chk("idle_err", 64'(err_unexp), 64'(2'b00));

        // Single read on port 0, manual return two cycles later
        cyc(); hst_read = 2'b01; hst_adr = 26'h0005; out_rdy = 2'b11; #2;
        chk("t2_read", 64'(read), 64'(2'b01));
        chk("t2_rd_adr", 64'(rd_adr), 64'(26'h0005));
        cyc(); hst_read = 2'b00;
        cyc(); man_vld = 2'b01; man_dout = 64'hDEADBEEF; man_serr = 2'b01; man_padr = 34'h1A2B; #2;
        chk("t2_vld_before", 64'(out_vld), 64'(2'b00));
        cyc(); man_vld = 2'b00; #2;
        chk("t2_vld", 64'(out_vld), 64'(2'b01));
        chk("t2_head", 64'(head(0)), 64'({1'b0, 1'b1, 17'h1A2B, 32'hDEADBEEF}));
        cyc(); #2;
        chk("t2_vld_after", 64'(out_vld), 64'(2'b00));
        chk("t2_rdy_after", 64'(hst_rdy), 64'(2'b11));

        // Port 1 credit exhaustion with out_rdy held low
        cyc(); out_rdy = 2'b00; mem_en = 1'b1;
        for (int k = 0; k < 10; k++) begin
            if (k > 0) cyc();
            hst_read = 2'b10;
            hst_adr  = {13'(16'h0100 + k), 13'h0000};
            #2;
            chk("t3_accept", 64'(read), 64'((k < 8) ? 2'b10 : 2'b00));
        end
        cyc(); hst_read = 2'b00; out_rdy = 2'b10; #2;
        chk("t3_full_rdy", 64'(hst_rdy), 64'(2'b01));
        chk("t3_full_vld", 64'(out_vld), 64'(2'b10));
        chk("t3_pop_head", 64'(head(1)), 64'(f_ent(1, 13'h0100)));
        cyc(); out_rdy = 2'b00; hst_read = 2'b10; hst_adr = {13'h0108, 13'h0000}; #2;
        chk("t3_credit_back", 64'(read), 64'(2'b10));
        cyc(); hst_read = 2'b00; #2;
        chk("t3_full_again", 64'(hst_rdy), 64'(2'b01));
        exp_adr = 13'h0101;
        for (int i = 0; i < 20 && exp_adr != 13'h0109; i++) begin
            cyc(); out_rdy = 2'b10; #2;
            if (out_vld[1]) begin
                chk("t3_drain", 64'(head(1)), 64'(f_ent(1, exp_adr)));
                exp_adr = exp_adr + 13'd1;
            end
        end
        chk("t3_drain_count", 64'(exp_adr), 64'(13'h0109));
        cyc(); out_rdy = 2'b00;

        // Both ports at full rate, out_rdy toggling; FIFO order checked per pop
        iss[0] = 0; iss[1] = 0; pc[0] = 0; pc[1] = 0;
        for (int c = 0; c < 1000 && !(pc[0] == 100 && pc[1] == 100); c++) begin
            cyc();
            hst_read = {iss[1] < 100, iss[0] < 100};
            hst_adr  = {13'(base[1] + 13'(iss[1])), 13'(base[0] + 13'(iss[0]))};
            out_rdy  = {c[0], c[0]};
            #2;
            for (int p = 0; p < 2; p++) begin
                if (read[p]) iss[p]++;
                if (out_vld[p] && out_rdy[p]) begin
                    chk("t4_pop", 64'(head(p)), 64'(f_ent(p, 13'(base[p] + 13'(pc[p])))));
                    pc[p]++;
                end
            end
        end
        chk("t4_pops_p0", 64'(pc[0]), 64'(100));
        chk("t4_pops_p1", 64'(pc[1]), 64'(100));
        chk("t4_iss_p0", 64'(iss[0]), 64'(100));
        chk("t4_iss_p1", 64'(iss[1]), 64'(100));
        cyc(); hst_read = 2'b00; out_rdy = 2'b00;
        repeat (3) cyc();
        mem_en = 1'b0;

        // Unexpected return on port 0
        cyc(); man_vld = 2'b01; #2;
        chk("t5_rdy_before", 64'(hst_rdy), 64'(2'b11));
        cyc(); man_vld = 2'b00; #2;
        chk("t5_err", 64'(err_unexp), 64'(2'b01));
        chk("t5_no_push", 64'(out_vld), 64'(2'b00));
        chk("t5_rdy_after", 64'(hst_rdy), 64'(2'b11));
        repeat (3) cyc();
        #2;
        chk("t5_err_sticky", 64'(err_unexp), 64'(2'b01));

        // Async reset with 3 buffered and 2 in flight
        for (int k = 0; k < 5; k++) begin
            cyc(); hst_read = 2'b01; hst_adr = {13'h0000, 13'(8'h20 + k)}; #2;
            chk("t6_issue", 64'(read), 64'(2'b01));
        end
        cyc(); hst_read = 2'b00;
        for (int i = 0; i < 3; i++) begin
            cyc(); man_vld = 2'b01; man_dout = 64'(32'h1111_0000 + i);
            man_serr = 2'b00; man_padr = '0;
        end
        cyc(); man_vld = 2'b00; #2;
        chk("t6_buffered", 64'(out_vld), 64'(2'b01));
        chk("t6_head", 64'(head(0)), 64'({2'b00, 17'h0, 32'h1111_0000}));
        #1 rst = 1'b0;
        #1;
        chk("t6_rst_vld", 64'(out_vld), 64'(2'b00));
        chk("t6_rst_err", 64'(err_unexp), 64'(2'b00));
        cyc(); rst = 1'b1; #2;
        chk("t6_post_vld", 64'(out_vld), 64'(2'b00));
        cyc(); man_vld = 2'b01; #2;
        chk("t6_err_pending", 64'(err_unexp), 64'(2'b00));
        cyc(); #2;
        chk("t6_late1_err", 64'(err_unexp), 64'(2'b01));
        cyc(); man_vld = 2'b00; #2;
        chk("t6_late2_err", 64'(err_unexp), 64'(2'b01));
        chk("t6_late_vld", 64'(out_vld), 64'(2'b00));
        chk("t6_rdy", 64'(hst_rdy), 64'(2'b11));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
